// File: rtl/fibonacci_bcd_engine.sv
// Fibonacci engine: packed-BCD iteration count in, F(n) out in binary and packed BCD.
// Serial BCD->binary (Horner), tagged binary iteration, then double-dabble BCD conversion.
module fibonacci_bcd_engine #(
   parameter int IN_DIGITS  = 2,
   parameter int IW         = 7,
   parameter int OUT_DIGITS = 4,
   parameter int W          = 14
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [4*IN_DIGITS-1:0]  iter_bcd_i,
   output logic                    ready_o,
   output logic                    done_o,
   output logic [IW-1:0]           iter_o,
   output logic [W-1:0]            fib_bin_o,
   output logic [4*OUT_DIGITS-1:0] fib_bcd_o,
   output logic                    overflow_o,
   output logic                    invalid_o
);

   // state   | meaning
   // IDLE    | ready for a request, start_i sampled
   // BCD2BIN | one input digit per cycle, MSD first
   // FIB     | one Fibonacci step per cycle until cnt reaches 0
   // BIN2BCD | one binary bit per cycle into the BCD shifter
   // DONE    | results updated, done_o pulse
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      BCD2BIN = 3'd1,
      FIB     = 3'd2,
      BIN2BCD = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam int BW  = 4*IN_DIGITS;
   localparam int OW  = 4*OUT_DIGITS;
   localparam int DCW = $clog2(IN_DIGITS + 1);
   localparam int BCW = $clog2(W + 1);

   function automatic logic [63:0] pow10(input int d);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < d; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0] DEC_LIMIT = pow10(OUT_DIGITS);
   localparam logic [63:0] BIN_MAX   = (64'd1 << W) - 64'd1;
   localparam bit          DEC_CHECK = (BIN_MAX >= DEC_LIMIT);

   state_t state_q, state_d;

   logic [BW-1:0]  bcd_in_q;
   logic [DCW-1:0] dig_cnt_q;
   logic [IW-1:0]  acc_q;
   logic           bad_digit_q;
   logic [IW-1:0]  cnt_q;
   logic [W-1:0]   t0_q, t1_q;
   logic           ovf0_q, ovf1_q;
   logic [W-1:0]   sh_q;
   logic [OW-1:0]  dab_q;
   logic [BCW-1:0] bit_cnt_q;

   logic [IW-1:0]   iter_q;
   logic [W-1:0]    fib_bin_q;
   logic [OW-1:0]   fib_bcd_q;
   logic            overflow_q;
   logic            invalid_q;

   logic [3:0]    digit;
   logic          bad_any;
   logic [IW-1:0] acc_next;
   logic [W:0]    fib_sum;
   logic [63:0]   t0_ext;
   logic          dec_ovf;
   logic [OW-1:0] dab_adj;
   logic [OW-1:0] dab_next;

   always_comb begin
      digit    = bcd_in_q[BW-1 -: 4];
      bad_any  = bad_digit_q | (digit > 4'd9);
      acc_next = (acc_q << 3) + (acc_q << 1) + IW'(digit);
      fib_sum  = {1'b0, t0_q} + {1'b0, t1_q};
      t0_ext   = 64'(t0_q);
      dec_ovf  = DEC_CHECK && (t0_ext >= DEC_LIMIT);
   end

   // Double-dabble correction: any nibble >= 5 would carry past 9 after the shift.
   always_comb begin
      dab_adj = dab_q;
      for (int i = 0; i < OUT_DIGITS; i++) begin
         if (dab_q[4*i +: 4] >= 4'd5) dab_adj[4*i +: 4] = dab_q[4*i +: 4] + 4'd3;
      end
      dab_next = (dab_adj << 1) | OW'(sh_q[W-1]);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = BCD2BIN;
         end
         BCD2BIN: begin
            if (dig_cnt_q == '0) state_d = bad_any ? DONE : FIB;
         end
         FIB: begin
            if (cnt_q == '0) state_d = (ovf0_q || dec_ovf) ? DONE : BIN2BCD;
         end
         BIN2BCD: begin
            if (bit_cnt_q == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         bcd_in_q    <= '0;
         dig_cnt_q   <= '0;
         acc_q       <= '0;
         bad_digit_q <= 1'b0;
         cnt_q       <= '0;
         t0_q        <= '0;
         t1_q        <= '0;
         ovf0_q      <= 1'b0;
         ovf1_q      <= 1'b0;
         sh_q        <= '0;
         dab_q       <= '0;
         bit_cnt_q   <= '0;
         iter_q      <= '0;
         fib_bin_q   <= '0;
         fib_bcd_q   <= '0;
         overflow_q  <= 1'b0;
         invalid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  bcd_in_q    <= iter_bcd_i;
                  dig_cnt_q   <= DCW'(IN_DIGITS - 1);
                  acc_q       <= '0;
                  bad_digit_q <= 1'b0;
               end
            end
            BCD2BIN: begin
               acc_q       <= acc_next;
               bad_digit_q <= bad_any;
               bcd_in_q    <= bcd_in_q << 4;
               if (dig_cnt_q != '0) begin
                  dig_cnt_q <= dig_cnt_q - DCW'(1);
               end else if (bad_any) begin
                  iter_q     <= acc_next;
                  fib_bin_q  <= '0;
                  fib_bcd_q  <= '0;
                  overflow_q <= 1'b0;
                  invalid_q  <= 1'b1;
               end else begin
                  cnt_q  <= acc_next;
                  t0_q   <= '0;
                  t1_q   <= W'(1);
                  ovf0_q <= 1'b0;
                  ovf1_q <= 1'b0;
               end
            end
            FIB: begin
               if (cnt_q != '0) begin
                  // ovf1 tags t1, ovf0 tags t0; a tag follows its value down the pair.
                  t0_q   <= t1_q;
                  t1_q   <= fib_sum[W-1:0];
                  ovf1_q <= fib_sum[W] | ovf0_q | ovf1_q;
                  ovf0_q <= ovf1_q;
                  cnt_q  <= cnt_q - IW'(1);
               end else if (ovf0_q) begin
                  iter_q     <= acc_q;
                  fib_bin_q  <= '1;
                  fib_bcd_q  <= {OUT_DIGITS{4'h9}};
                  overflow_q <= 1'b1;
                  invalid_q  <= 1'b0;
               end else if (dec_ovf) begin
                  iter_q     <= acc_q;
                  fib_bin_q  <= t0_q;
                  fib_bcd_q  <= {OUT_DIGITS{4'h9}};
                  overflow_q <= 1'b1;
                  invalid_q  <= 1'b0;
               end else begin
                  sh_q      <= t0_q;
                  dab_q     <= '0;
                  bit_cnt_q <= BCW'(W - 1);
               end
            end
            BIN2BCD: begin
               dab_q <= dab_next;
               sh_q  <= sh_q << 1;
               if (bit_cnt_q != '0) begin
                  bit_cnt_q <= bit_cnt_q - BCW'(1);
               end else begin
                  iter_q     <= acc_q;
                  fib_bin_q  <= t0_q;
                  fib_bcd_q  <= dab_next;
                  overflow_q <= 1'b0;
                  invalid_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_o    = (state_q == IDLE);
   assign done_o     = (state_q == DONE);
   assign iter_o     = iter_q;
   assign fib_bin_o  = fib_bin_q;
   assign fib_bcd_o  = fib_bcd_q;
   assign overflow_o = overflow_q;
   assign invalid_o  = invalid_q;

endmodule
